// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x-style oversampling, one-deep holding register.
// Ports: clk, reset (sync, active-high), rx_en tick, rx_in line, read_en ack;
//        rx_out byte, rx_valid level, frame_err/overrun pulses, busy.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx_in,
  input  logic       read_en,
  output logic [7:0] rx_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] HALF_LAST =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST =
    TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          sync_q;
  logic          rx_s;

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;

  logic [7:0]    out_d;
  logic          valid_d;
  logic          ferr_d;
  logic          ovr_d;

  logic          tick_half;
  logic          tick_full;

  assign tick_half = (tick_q == HALF_LAST);
  assign tick_full = (tick_q == FULL_LAST);

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_out    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_q    <= rx_in;
      rx_s      <= sync_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_out    <= out_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = rx_out;
    // a read drops the held byte unless a load
    // overrides it below in the same cycle
    valid_d = rx_valid & ~read_en;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (rx_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        START: begin
          if (!tick_half) begin
            tick_d = tick_q + TICK_ONE;
          end else if (!rx_s) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            // line rose before mid-start: glitch
            state_d = IDLE;
            tick_d  = '0;
          end
        end

        DATA: begin
          if (!tick_full) begin
            tick_d = tick_q + TICK_ONE;
          end else begin
            shift_d = {rx_s, shift_q[7:1]};
            tick_d  = '0;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end

        STOP: begin
          if (!tick_full) begin
            tick_d = tick_q + TICK_ONE;
          end else begin
            tick_d = '0;
            if (rx_s) begin
              out_d   = shift_q;
              valid_d = 1'b1;
              ovr_d   = rx_valid & ~read_en;
              state_d = IDLE;
            end else begin
              // keep the old byte; hold off until
              // the line idles so a break is one error
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_d = IDLE;
            tick_d  = '0;
          end
        end

        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

endmodule
